// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline MEM stage: control-field bit positions,
// the memory-wait state type and an alignment helper.
package pipeline_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Word accesses only: the two byte-offset bits must be clear.
    function automatic logic is_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface memory_access_if #(
    parameter int DATA_W = 32
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_wait_ctrl.sv
// Wait-state controller for the MEM stage: tracks an outstanding access,
// generates the pipeline stall, and gives up after TIMEOUT cycles.
module mem_wait_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic dmem_ack,
    output logic stall,
    output logic dmem_req_hold,
    output logic timeout,
    output logic complete
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LAST);

    // Stall and request must react within the cycle the ack arrives,
    // so these are decoded from state rather than registered.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        stall         = 1'b0;
        timeout       = 1'b0;
        complete      = 1'b0;
        dmem_req_hold = 1'b0;
        unique case (r_state)
            IDLE: begin
                complete = access & dmem_ack;
                stall    = access & ~dmem_ack;
            end
            WAIT: begin
                dmem_req_hold = 1'b1;
                complete      = dmem_ack;
                timeout       = ~dmem_ack & w_at_limit;
                stall         = ~dmem_ack & ~w_at_limit;
            end
            default: ;
        endcase
        if (rst) begin
            stall         = 1'b0;
            dmem_req_hold = 1'b0;
            timeout       = 1'b0;
            complete      = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (access && !dmem_ack) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ack || w_at_limit) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_access.sv
// Pipeline MEM stage: data-memory load/store with stall/timeout/misalign
// handling, branch select, and the MEM/WB pipeline register.
module memory_access
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] res,
    input  logic [DATA_W-1:0] write_data_ex,
    input  logic [REG_W-1:0]  write_register,
    input  logic              zero,
    input  logic [2:0]        m_MEM,
    input  logic [1:0]        wb_MEM,
    output logic              pcsrc,
    output logic              stall,
    memory_access_if.master   dmem,
    output logic [DATA_W-1:0] read_data_wb,
    output logic [DATA_W-1:0] alu_res_wb,
    output logic [REG_W-1:0]  write_register_wb,
    output logic [1:0]        wb_WB,
    output logic              bus_err,
    output logic              misaligned
);

    logic w_mem_op;
    logic w_aligned;
    logic w_access;
    logic w_misaligned;
    logic w_is_load;
    logic w_stall;
    logic w_req_hold;
    logic w_timeout;
    logic w_complete;
    logic w_bubble;

    logic [DATA_W-1:0] r_read_data;
    logic [DATA_W-1:0] r_alu_res;
    logic [REG_W-1:0]  r_write_register;
    logic [1:0]        r_wb;
    logic              r_bus_err;
    logic              r_misaligned;

    assign w_mem_op     = m_MEM[M_READ] | m_MEM[M_WRITE];
    assign w_aligned    = is_aligned(res[1:0]);
    assign w_access     = w_mem_op & w_aligned;
    assign w_misaligned = w_mem_op & ~w_aligned;
    // Read+write together is treated as a store, so only a pure read captures data.
    assign w_is_load    = m_MEM[M_READ] & ~m_MEM[M_WRITE];

    mem_wait_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctrl (
        .clk           (clk),
        .rst           (rst),
        .access        (w_access),
        .dmem_ack      (dmem.dmem_ack),
        .stall         (w_stall),
        .dmem_req_hold (w_req_hold),
        .timeout       (w_timeout),
        .complete      (w_complete)
    );

    assign dmem.dmem_req   = ~rst & (w_access | w_req_hold);
    assign dmem.dmem_we    = m_MEM[M_WRITE];
    assign dmem.dmem_addr  = res;
    assign dmem.dmem_wdata = write_data_ex;

    assign stall = w_stall;
    assign pcsrc = m_MEM[M_BRANCH] & zero;

    // Any memory op that is not completing this cycle (pending, timed out or
    // misaligned) must not reach write-back.
    assign w_bubble = w_misaligned | (w_access & ~w_complete);

    // NOTE: only the MEM/WB flops are reset here; nothing in this stage is a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data      <= '0;
            r_alu_res        <= '0;
            r_write_register <= '0;
            r_wb             <= '0;
            r_bus_err        <= 1'b0;
            r_misaligned     <= 1'b0;
        end else begin
            r_alu_res        <= res;
            r_write_register <= write_register;
            r_wb             <= w_bubble ? 2'b00 : wb_MEM;
            r_bus_err        <= w_timeout;
            r_misaligned     <= w_misaligned;
            if (w_complete && w_is_load) begin
                r_read_data <= dmem.dmem_rdata;
            end
        end
    end

    assign read_data_wb      = r_read_data;
    assign alu_res_wb        = r_alu_res;
    assign write_register_wb = r_write_register;
    assign wb_WB             = r_wb;
    assign bus_err           = r_bus_err;
    assign misaligned        = r_misaligned;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: single-cycle vector table plus hand
// sequences for wait states, timeout and reset during a pending access.
module tb_memory_access;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] write_data_ex;
    logic [REG_W-1:0]  write_register;
    logic              zero;
    logic [2:0]        m_MEM;
    logic [1:0]        wb_MEM;
    logic              pcsrc;
    logic              stall;
    logic [DATA_W-1:0] read_data_wb;
    logic [DATA_W-1:0] alu_res_wb;
    logic [REG_W-1:0]  write_register_wb;
    logic [1:0]        wb_WB;
    logic              bus_err;
    logic              misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access_if #(.DATA_W(DATA_W)) dmem_bus ();

    memory_access #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .res               (res),
        .write_data_ex     (write_data_ex),
        .write_register    (write_register),
        .zero              (zero),
        .m_MEM             (m_MEM),
        .wb_MEM            (wb_MEM),
        .pcsrc             (pcsrc),
        .stall             (stall),
        .dmem              (dmem_bus),
        .read_data_wb      (read_data_wb),
        .alu_res_wb        (alu_res_wb),
        .write_register_wb (write_register_wb),
        .wb_WB             (wb_WB),
        .bus_err           (bus_err),
        .misaligned        (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        zero;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic        ack;
        logic        e_pcsrc;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [1:0]  e_wb;
        logic [31:0] e_rd;
        logic        e_mis;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] wd, input logic [4:0] wr,
                         input logic z, input logic [2:0] m, input logic [1:0] wb,
                         input logic [31:0] rd, input logic ack);
        res                 = r;
        write_data_ex       = wd;
        write_register      = wr;
        zero                = z;
        m_MEM               = m;
        wb_MEM              = wb;
        dmem_bus.dmem_rdata = rd;
        dmem_bus.dmem_ack   = ack;
    endtask

    task automatic drive_idle();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];

    initial begin
        int stalls;
        int early_err;
        int stray_stall;
        logic done;

        vecs[0] = '{"zw_load",   32'h10,   32'h0,  5'd5,  1'b0, 3'b010, 2'b11, 32'hDEADBEEF, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{"br_taken",  32'h100,  32'h0,  5'd0,  1'b1, 3'b100, 2'b00, 32'h12345678, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{"br_not",    32'h104,  32'h0,  5'd0,  1'b0, 3'b100, 2'b00, 32'h0,        1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{"alu_op",    32'h1234, 32'h0,  5'd7,  1'b1, 3'b000, 2'b10, 32'h0,        1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{"mis_load",  32'h13,   32'h0,  5'd9,  1'b0, 3'b010, 2'b11, 32'hAAAA5555, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 1'b1};
        vecs[5] = '{"zw_store",  32'h24,   32'h77, 5'd0,  1'b0, 3'b001, 2'b00, 32'hBBBB0000, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 1'b0};
        vecs[6] = '{"rw_store",  32'h28,   32'h99, 5'd3,  1'b0, 3'b011, 2'b10, 32'hCCCC0000, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'hDEADBEEF, 1'b0};
        vecs[7] = '{"mis_store", 32'h22,   32'h66, 5'd0,  1'b0, 3'b001, 2'b00, 32'h0,        1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'hDEADBEEF, 1'b1};
        vecs[8] = '{"zw_load2",  32'h40,   32'h0,  5'd12, 1'b0, 3'b010, 2'b11, 32'h0BADF00D, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h0BADF00D, 1'b0};

        // Reset with an aligned load presented: bus and stall must stay quiet.
        rst = 1'b1;
        drive(32'h10, 32'h0, 5'd3, 1'b0, 3'b010, 2'b11, 32'h0, 1'b0);
        #3;
        check("rst_req",   32'(dmem_bus.dmem_req), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        edge_sample();
        edge_sample();
        check("rst_wb",    32'(wb_WB), 32'h0);
        check("rst_rd",    read_data_wb, 32'h0);
        check("rst_alu",   alu_res_wb, 32'h0);
        check("rst_wreg",  32'(write_register_wb), 32'h0);
        check("rst_err",   32'(bus_err), 32'h0);
        check("rst_mis",   32'(misaligned), 32'h0);
        drive_idle();
        rst = 1'b0;
        edge_sample();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].res, vecs[i].wdata, vecs[i].wreg, vecs[i].zero, vecs[i].m,
                  vecs[i].wb, vecs[i].rdata, vecs[i].ack);
            #1;
            check({vecs[i].name, "_pcsrc"}, 32'(pcsrc), 32'(vecs[i].e_pcsrc));
            check({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].e_stall));
            check({vecs[i].name, "_req"},   32'(dmem_bus.dmem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                check({vecs[i].name, "_we"},    32'(dmem_bus.dmem_we), 32'(vecs[i].e_we));
                check({vecs[i].name, "_addr"},  dmem_bus.dmem_addr, vecs[i].res);
                check({vecs[i].name, "_wdata"}, dmem_bus.dmem_wdata, vecs[i].wdata);
            end
            edge_sample();
            check({vecs[i].name, "_wb"},   32'(wb_WB), 32'(vecs[i].e_wb));
            check({vecs[i].name, "_rd"},   read_data_wb, vecs[i].e_rd);
            check({vecs[i].name, "_alu"},  alu_res_wb, vecs[i].res);
            check({vecs[i].name, "_wreg"}, 32'(write_register_wb), 32'(vecs[i].wreg));
            check({vecs[i].name, "_mis"},  32'(misaligned), 32'(vecs[i].e_mis));
            check({vecs[i].name, "_err"},  32'(bus_err), 32'h0);
        end

        // Store with three wait cycles, completing on the fourth edge.
        drive(32'h20, 32'h55, 5'd6, 1'b0, 3'b001, 2'b10, 32'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("st3_stall", 32'(stall), 32'h1);
            check("st3_req",   32'(dmem_bus.dmem_req), 32'h1);
            check("st3_we",    32'(dmem_bus.dmem_we), 32'h1);
            check("st3_wdata", dmem_bus.dmem_wdata, 32'h55);
            check("st3_addr",  dmem_bus.dmem_addr, 32'h20);
            edge_sample();
            check("st3_bubble", 32'(wb_WB), 32'h0);
        end
        dmem_bus.dmem_ack = 1'b1;
        #1;
        check("st3_ack_stall", 32'(stall), 32'h0);
        check("st3_ack_req",   32'(dmem_bus.dmem_req), 32'h1);
        edge_sample();
        check("st3_done_wb",   32'(wb_WB), 32'h2);
        check("st3_done_rd",   read_data_wb, 32'h0BADF00D);
        drive_idle();
        edge_sample();

        // Load that is never acknowledged must time out.
        drive(32'h30, 32'h0, 5'd8, 1'b0, 3'b010, 2'b11, 32'hFFFFFFFF, 1'b0);
        stalls    = 0;
        early_err = 0;
        done      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            edge_sample();
            if (bus_err) early_err++;
            check("to_bubble", 32'(wb_WB), 32'h0);
        end
        check("to_finished",    32'(done), 32'h1);
        check("to_stall_count", 32'(stalls), 32'(TIMEOUT - 1));
        check("to_early_err",   32'(early_err), 32'h0);
        edge_sample();
        check("to_bus_err", 32'(bus_err), 32'h1);
        check("to_wb",      32'(wb_WB), 32'h0);
        check("to_rd_hold", read_data_wb, 32'h0BADF00D);
        drive_idle();
        #1;
        check("to_idle_stall", 32'(stall), 32'h0);
        check("to_idle_req",   32'(dmem_bus.dmem_req), 32'h0);
        edge_sample();
        check("to_err_pulse",  32'(bus_err), 32'h0);

        // Reset on the second cycle of a pending load.
        drive(32'h50, 32'h0, 5'd4, 1'b0, 3'b010, 2'b11, 32'h0, 1'b0);
        #1;
        check("rw_stall1", 32'(stall), 32'h1);
        edge_sample();
        check("rw_stall2", 32'(stall), 32'h1);
        check("rw_req2",   32'(dmem_bus.dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        check("rw_req_drop",   32'(dmem_bus.dmem_req), 32'h0);
        check("rw_stall_drop", 32'(stall), 32'h0);
        check("rw_wb",   32'(wb_WB), 32'h0);
        check("rw_rd",   read_data_wb, 32'h0);
        check("rw_alu",  alu_res_wb, 32'h0);
        check("rw_wreg", 32'(write_register_wb), 32'h0);
        check("rw_err",  32'(bus_err), 32'h0);
        check("rw_mis",  32'(misaligned), 32'h0);
        edge_sample();
        check("rw_hold_req", 32'(dmem_bus.dmem_req), 32'h0);
        drive_idle();
        rst = 1'b0;
        stray_stall = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (stall || dmem_bus.dmem_req || bus_err) stray_stall++;
            edge_sample();
        end
        check("rw_idle_quiet", 32'(stray_stall), 32'h0);
        drive(32'h60, 32'h0, 5'd10, 1'b0, 3'b010, 2'b11, 32'h600DCAFE, 1'b1);
        #1;
        check("rw_after_stall", 32'(stall), 32'h0);
        check("rw_after_req",   32'(dmem_bus.dmem_req), 32'h1);
        edge_sample();
        check("rw_after_rd",    read_data_wb, 32'h600DCAFE);
        check("rw_after_wb",    32'(wb_WB), 32'h3);
        drive_idle();
        edge_sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
